forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 forward_en  in  1  1 = forwarding mode; 0 = stall-only mode.
REQ-008 flush  in  1  kill the instruction currently in ID.
REQ-009 id_valid  in  1  ID holds a real instruction.
REQ-010 id_wb_en  in  1  ID instruction writes a register.
REQ-011 id_is_load  in  1  ID instruction is a memory read.
REQ-012 id_dest  in  REG_W  ID destination register.
REQ-013 id_src  in  NUM_SRC*REG_W  source i at bits [i*REG_W +: REG_W].
REQ-014 id_src_used  in  NUM_SRC  bit i = source i is read.
REQ-015 stall  out  1  combinational; hold IF/ID, bubble EXE.
REQ-016 sel_src  out  2*NUM_SRC  registered; field i at [2i +: 2]: 00 regfile, 01 MEM result, 10 WB result; 11 never driven.
REQ-017 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 SHALL hold three internal stage entries EXE, MEM, WB, each {valid, wb_en, is_load, dest}.
REQ-019 Every clock SHALL shift WB<=MEM, MEM<=EXE; no stage ever holds.
REQ-020 "issue" = id_valid & !flush & !stall; on issue EXE<=ID fields, else EXE<=bubble (valid=0).
REQ-021 Match(S,i) = S.valid & S.wb_en & id_src_used[i] & (id_src[i]==S.dest).
REQ-022 forward_en=1: stall = id_valid & !flush & OR over i of Match(EXE,i) with EXE.is_load (load-use).
REQ-023 forward_en=0: stall = id_valid & !flush & OR over i of (Match(EXE,i) | Match(MEM,i)).
REQ-024 On issue with forward_en=1, sel field i SHALL register 01 if Match(EXE,i), else 10 if Match(MEM,i), else 00 (EXE priority = youngest producer).
REQ-025 On issue with forward_en=0, all sel fields SHALL register 00.
REQ-026 When no issue, sel_src SHALL register all zeros; sel_src is valid the cycle the instruction occupies EXE (1-cycle latency from issue).
REQ-027 flush SHALL override stall: flush=1 forces stall=0 and a bubble into EXE.
REQ-028 Destination register value itself SHALL not be special-cased (any dest incl. all-ones matchable).
REQ-029 Both sources matching the same stage SHALL each receive the same code independently.
REQ-030 stall_cnt SHALL increment once per cycle stall=1 and saturate at all ones.
REQ-031 forward_en change SHALL take effect on the same cycle's stall and sel computation; no pipeline drain.

Reset
REQ-032 rst=1 SHALL asynchronously clear all stage valids, sel_src=0, stall_cnt=0; stall then reads 0 since no entry is valid.
REQ-033 Reset mid-stall SHALL drop the hazard; first post-reset issue sees empty stages.

Verification
REQ-034 forward_en=1, ADD r3 issued, next ID reads r3 -> stall=0, next cycle sel field = 01.
REQ-035 forward_en=1, ADD r3, NOP, ID reads r3 on src1 and src0 unused -> sel = 4'b1000.
REQ-036 forward_en=1, LDR r5, ID reads r5 -> stall=1 one cycle, stall_cnt=1, then issue with sel field 10.
REQ-037 forward_en=0, ADD r2, ID reads r2 -> stall=1 two cycles, then issue with sel=00, stall_cnt=2.
REQ-038 LDR r5 followed by ID reading r5 with flush=1 -> stall=0, EXE bubble, stall_cnt unchanged.
REQ-039 rst asserted during load-use stall -> stall=0 and stall_cnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/forward_scoreboard.sv
// Pipeline hazard scoreboard: tracks the EXE/MEM/WB producers, raises stall for
// unresolvable RAW hazards and registers per-source forwarding selects for EXE.
module forward_scoreboard #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       forward_en,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic                       id_wb_en,
    input  logic                       id_is_load,
    input  logic [REG_W-1:0]           id_dest,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    output logic                       stall,
    output logic [2*NUM_SRC-1:0]       sel_src,
    output logic [CNT_W-1:0]           stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             is_load;
        logic [REG_W-1:0] dest;
    } stage_t;

    stage_t               exe_q, mem_q, wb_q;
    stage_t               id_entry;
    logic [NUM_SRC-1:0]   match_exe, match_mem;
    logic [2*NUM_SRC-1:0] sel_next;
    logic                 hazard;
    logic                 issue;

    // The WB entry only completes the pipeline picture; nothing downstream reads it.
    logic                 unused_wb;
    assign unused_wb = ^wb_q;

    assign id_entry = '{valid: 1'b1, wb_en: id_wb_en, is_load: id_is_load, dest: id_dest};

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        match_exe = '0;
        match_mem = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            match_exe[i] = exe_q.valid & exe_q.wb_en & id_src_used[i]
                         & (id_src[i*REG_W +: REG_W] == exe_q.dest);
            match_mem[i] = mem_q.valid & mem_q.wb_en & id_src_used[i]
                         & (id_src[i*REG_W +: REG_W] == mem_q.dest);
        end
    end

    // With forwarding only a load still in EXE cannot deliver in time.
    always_comb begin
        hazard = 1'b0;
        if (forward_en)
            hazard = (|match_exe) & exe_q.is_load;
        else
            hazard = |(match_exe | match_mem);
    end

    assign stall = id_valid & ~flush & hazard;
    assign issue = id_valid & ~flush & ~stall;

    // EXE match wins: it is the youngest producer of the register.
    always_comb begin
        sel_next = '0;
        if (issue && forward_en) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (match_exe[i])
                    sel_next[2*i +: 2] = 2'b01;
                else if (match_mem[i])
                    sel_next[2*i +: 2] = 2'b10;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q     <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            sel_src   <= '0;
            stall_cnt <= '0;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= exe_q;
            exe_q   <= issue ? id_entry : '0;
            sel_src <= sel_next;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: hand-computed stall, select and
// stall-count values over forwarding, stall-only, flush and reset scenarios.
module tb_forward_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en;
    logic       flush;
    logic       id_valid;
    logic       id_wb_en;
    logic       id_is_load;
    logic [3:0] id_dest;
    logic [7:0] id_src;
    logic [1:0] id_src_used;
    logic       stall;
    logic [3:0] sel_src;
    logic [2:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    forward_scoreboard #(.REG_W(4), .NUM_SRC(2), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .forward_en  (forward_en),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_wb_en    (id_wb_en),
        .id_is_load  (id_is_load),
        .id_dest     (id_dest),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .stall       (stall),
        .sel_src     (sel_src),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic w, input logic l, input logic [3:0] d,
                          input logic [3:0] s1, input logic [3:0] s0, input logic [1:0] u);
        id_valid    = v;
        id_wb_en    = w;
        id_is_load  = l;
        id_dest     = d;
        id_src      = {s1, s0};
        id_src_used = u;
    endtask

    task automatic idle();
        set_id(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00);
    endtask

    task automatic pulse_reset();
        idle();
        flush = 1'b0;
        rst   = 1'b1;
        #2;
        rst   = 1'b0;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        forward_en = 1'b1;
        flush      = 1'b0;
        idle();
        #1;
        check("reset_stall", stall, 1'b0);
        check("reset_sel", sel_src, 4'b0000);
        check("reset_cnt", stall_cnt, 3'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ADD r3, then a reader of r3 on src0: forwarded from MEM result.
        set_id(1, 1, 0, 4'd3, 4'd0, 4'd0, 2'b00);
        #1 check("add_r3_stall", stall, 1'b0);
        tick();
        set_id(1, 1, 0, 4'd4, 4'd0, 4'd3, 2'b01);
        #1 check("exe_fwd_stall", stall, 1'b0);
        tick();
        check("exe_fwd_sel", sel_src, 4'b0001);

        // ADD r3, NOP, reader of r3 on src1 only: forwarded from WB result.
        set_id(1, 1, 0, 4'd3, 4'd0, 4'd0, 2'b00);
        tick();
        idle();
        tick();
        check("nop_sel_zero", sel_src, 4'b0000);
        set_id(1, 0, 0, 4'd0, 4'd3, 4'd0, 2'b10);
        #1 check("mem_fwd_stall", stall, 1'b0);
        tick();
        check("mem_fwd_sel", sel_src, 4'b1000);

        // Dest all-ones, both sources match EXE; an older MEM match loses to EXE.
        idle();
        tick(); tick(); tick();
        set_id(1, 1, 0, 4'd15, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(1, 1, 0, 4'd15, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(1, 0, 0, 4'd0, 4'd15, 4'd15, 2'b11);
        #1 check("both_src_stall", stall, 1'b0);
        tick();
        check("both_src_exe_prio_sel", sel_src, 4'b0101);

        // Load-use: one stall cycle, then forwarded from WB.
        pulse_reset();
        set_id(1, 1, 1, 4'd5, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(1, 1, 0, 4'd6, 4'd0, 4'd5, 2'b01);
        #1 check("load_use_stall", stall, 1'b1);
        tick();
        check("load_use_cnt", stall_cnt, 3'd1);
        check("load_use_bubble_sel", sel_src, 4'b0000);
        check("load_use_release", stall, 1'b0);
        tick();
        check("load_use_sel", sel_src, 4'b0010);

        // Stall-only mode: two stall cycles, then issue with regfile select.
        pulse_reset();
        forward_en = 1'b0;
        set_id(1, 1, 0, 4'd2, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(1, 1, 0, 4'd7, 4'd0, 4'd2, 2'b01);
        #1 check("nofwd_stall_1", stall, 1'b1);
        tick();
        check("nofwd_stall_2", stall, 1'b1);
        tick();
        check("nofwd_release", stall, 1'b0);
        check("nofwd_cnt", stall_cnt, 3'd2);
        tick();
        check("nofwd_sel", sel_src, 4'b0000);

        // forward_en flipped with the hazard in ID takes effect immediately.
        pulse_reset();
        set_id(1, 1, 0, 4'd2, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(1, 0, 0, 4'd0, 4'd0, 4'd2, 2'b01);
        #1 check("mode_switch_stall_off", stall, 1'b1);
        forward_en = 1'b1;
        #1 check("mode_switch_stall_on", stall, 1'b0);
        tick();
        check("mode_switch_sel", sel_src, 4'b0001);

        // Flush overrides a load-use stall and bubbles EXE.
        pulse_reset();
        set_id(1, 1, 1, 4'd5, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(1, 1, 0, 4'd6, 4'd0, 4'd5, 2'b01);
        flush = 1'b1;
        #1 check("flush_stall", stall, 1'b0);
        tick();
        flush = 1'b0;
        check("flush_cnt", stall_cnt, 3'd0);
        check("flush_sel", sel_src, 4'b0000);
        #1 check("flush_next_stall", stall, 1'b0);
        tick();
        check("flush_next_sel", sel_src, 4'b0010);

        // Reset asserted in the middle of a load-use stall.
        pulse_reset();
        set_id(1, 1, 1, 4'd5, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(1, 1, 1, 4'd6, 4'd0, 4'd5, 2'b01);
        tick();
        tick();
        set_id(1, 0, 0, 4'd0, 4'd0, 4'd6, 2'b01);
        #1 check("pre_reset_stall", stall, 1'b1);
        check("pre_reset_cnt", stall_cnt, 3'd1);
        rst = 1'b1;
        #1 check("async_reset_stall", stall, 1'b0);
        check("async_reset_cnt", stall_cnt, 3'd0);
        check("async_reset_sel", sel_src, 4'b0000);
        #1 rst = 1'b0;
        tick();
        check("post_reset_sel", sel_src, 4'b0000);
        check("post_reset_cnt", stall_cnt, 3'd0);

        // Self-dependent instruction held in ID under stall-only mode drives the counter to saturation.
        pulse_reset();
        forward_en = 1'b0;
        set_id(1, 1, 0, 4'd2, 4'd0, 4'd2, 2'b01);
        for (int i = 0; i < 20; i++) tick();
        check("cnt_saturate", stall_cnt, 3'd7);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
